// File: rtl/memory_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and a single-port data RAM (slave).
// The RAM returns mem_rdata combinationally for mem_addr and commits writes on the rising clock edge.
interface memory_stage_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_we;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_wstrb, mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wstrb, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/memory_stage_lsu.sv
// Dual-lane MEM stage: serialises same-cycle lane accesses onto one data-RAM port and registers MEM/WB.
// Optional macro MISALIGN_TRAP_EN: suppress misaligned H/W accesses and pulse misalign_o.
module memory_stage_lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM1,
  input  logic        RegWriteM2,
  input  logic [1:0]  ResultSrcM1,
  input  logic [1:0]  ResultSrcM2,
  input  logic        MemWriteM1,
  input  logic        MemWriteM2,
  input  logic [2:0]  AddressingControlM1,
  input  logic [2:0]  AddressingControlM2,
  input  logic [31:0] ALUResultM1,
  input  logic [31:0] ALUResultM2,
  input  logic [31:0] WriteDataM1,
  input  logic [31:0] WriteDataM2,
  input  logic [4:0]  RdM1,
  input  logic [4:0]  RdM2,
  input  logic [31:0] PCPlus4M1,
  input  logic [31:0] PCPlus4M2,
  memory_stage_lsu_if.master mem,
  output logic        stall_o,
  output logic        RegWriteW1,
  output logic        RegWriteW2,
  output logic [1:0]  ResultSrcW1,
  output logic [1:0]  ResultSrcW2,
  output logic [31:0] ALUResultW1,
  output logic [31:0] ALUResultW2,
  output logic [31:0] ReadDataW1,
  output logic [31:0] ReadDataW2,
  output logic [4:0]  RdW1,
  output logic [4:0]  RdW2,
  output logic [31:0] PCPlus4W1,
  output logic [31:0] PCPlus4W2,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;
  state_t state, state_nxt;

  logic        acc1, acc2, serve1, serve2;
  logic        sel_we, mis_sel, rw1_eff, rw2_eff;
  logic [31:0] sel_addr, sel_wd, rdata_ext, rd1, rd2;
  logic [2:0]  sel_f3;

  logic        hold_rw;
  logic [1:0]  hold_rs;
  logic [31:0] hold_alu, hold_rdata, hold_pc;
  logic [4:0]  hold_rd;
`ifdef MISALIGN_TRAP_EN
  logic        hold_mis;
`endif

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] sh;
    logic [15:0] h;
    sh = d >> {a, 3'b000};
    h  = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'b0, sh[7:0]};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = d;
    endcase
  endfunction

  assign acc1      = MemWriteM1 | (ResultSrcM1 == 2'b01);
  assign acc2      = MemWriteM2 | (ResultSrcM2 == 2'b01);
  assign state_dbg = (state == SECOND);

  // Upstream handshake: stall_o=1 means the EX/MEM register must hold both lanes
  // unchanged for the next cycle; the pair retires together once stall_o drops.
  always_comb begin
    serve1    = 1'b0;
    serve2    = 1'b0;
    stall_o   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc1 && acc2) begin
          serve1    = 1'b1;
          stall_o   = !rst;
          state_nxt = SECOND;
        end else begin
          serve1 = acc1;
          serve2 = acc2;
        end
      end
      SECOND: begin
        serve2    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_addr  = serve2 ? ALUResultM2 : ALUResultM1;
  assign sel_wd    = serve2 ? WriteDataM2 : WriteDataM1;
  assign sel_f3    = serve2 ? AddressingControlM2 : AddressingControlM1;
  assign sel_we    = serve2 ? MemWriteM2 : (serve1 & MemWriteM1);

`ifdef MISALIGN_TRAP_EN
  assign mis_sel = (serve1 | serve2) &
                   (((sel_f3[1:0] == 2'b01) & sel_addr[0]) |
                    ((sel_f3[1:0] == 2'b10) & (sel_addr[1:0] != 2'b00)));
`else
  assign mis_sel = 1'b0;
`endif

  assign mem.mem_addr  = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem.mem_we    = sel_we & !mis_sel & !rst;
  assign mem.mem_wdata = (sel_f3[1:0] == 2'b00) ? {4{sel_wd[7:0]}} :
                         (sel_f3[1:0] == 2'b01) ? {2{sel_wd[15:0]}} : sel_wd;
  assign mem.mem_wstrb = !mem.mem_we ? 4'b0000 :
                         (sel_f3[1:0] == 2'b00) ? (4'b0001 << sel_addr[1:0]) :
                         (sel_f3[1:0] == 2'b01) ? (sel_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

  assign rdata_ext = load_ext(mem.mem_rdata, sel_f3, sel_addr[1:0]);
  assign rd1       = (serve1 && ResultSrcM1 == 2'b01) ? rdata_ext : 32'b0;
  assign rd2       = (serve2 && ResultSrcM2 == 2'b01) ? rdata_ext : 32'b0;
  assign rw1_eff   = RegWriteM1 & !(serve1 & mis_sel);
  assign rw2_eff   = RegWriteM2 & !(serve2 & mis_sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_rw     <= 1'b0;
      hold_rs     <= 2'b0;
      hold_alu    <= 32'b0;
      hold_rdata  <= 32'b0;
      hold_rd     <= 5'b0;
      hold_pc     <= 32'b0;
      RegWriteW1  <= 1'b0;
      RegWriteW2  <= 1'b0;
      ResultSrcW1 <= 2'b0;
      ResultSrcW2 <= 2'b0;
      ALUResultW1 <= 32'b0;
      ALUResultW2 <= 32'b0;
      ReadDataW1  <= 32'b0;
      ReadDataW2  <= 32'b0;
      RdW1        <= 5'b0;
      RdW2        <= 5'b0;
      PCPlus4W1   <= 32'b0;
      PCPlus4W2   <= 32'b0;
`ifdef MISALIGN_TRAP_EN
      hold_mis    <= 1'b0;
      misalign_o  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && stall_o) begin
        // Lane 1 is parked until lane 2 is served; only RegWrite matters for the bubble.
        hold_rw    <= rw1_eff;
        hold_rs    <= ResultSrcM1;
        hold_alu   <= ALUResultM1;
        hold_rdata <= rd1;
        hold_rd    <= RdM1;
        hold_pc    <= PCPlus4M1;
        RegWriteW1 <= 1'b0;
        RegWriteW2 <= 1'b0;
`ifdef MISALIGN_TRAP_EN
        hold_mis   <= mis_sel;
        misalign_o <= 1'b0;
`endif
      end else begin
        if (state == SECOND) begin
          RegWriteW1  <= hold_rw;
          ResultSrcW1 <= hold_rs;
          ALUResultW1 <= hold_alu;
          ReadDataW1  <= hold_rdata;
          RdW1        <= hold_rd;
          PCPlus4W1   <= hold_pc;
        end else begin
          RegWriteW1  <= rw1_eff;
          ResultSrcW1 <= ResultSrcM1;
          ALUResultW1 <= ALUResultM1;
          ReadDataW1  <= rd1;
          RdW1        <= RdM1;
          PCPlus4W1   <= PCPlus4M1;
        end
        RegWriteW2  <= rw2_eff;
        ResultSrcW2 <= ResultSrcM2;
        ALUResultW2 <= ALUResultM2;
        ReadDataW2  <= rd2;
        RdW2        <= RdM2;
        PCPlus4W2   <= PCPlus4M2;
`ifdef MISALIGN_TRAP_EN
        misalign_o  <= mis_sel | ((state == SECOND) & hold_mis);
`endif
      end
    end
  end

endmodule
